// File: rtl/ahb_lite_interconnect.sv
// AHB-Lite address decoder and response mux with a built-in default slave that answers unmapped transfers with ERROR.
// Decode is combinational with zero latency; data-phase ownership advances only when HREADY=1, so slave wait states stall it.
module ahb_lite_interconnect #(
  parameter int NUM_SLAVES  = 4,
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 32,
  parameter int REGION_BITS = 10
) (
  input  logic                             HCLK,
  input  logic                             HRESET,
  input  logic [ADDR_WIDTH-1:0]            HADDR,
  input  logic [1:0]                       HTRANS,
  output logic [NUM_SLAVES-1:0]            HSEL_VEC,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] HRDATA_S,
  input  logic [NUM_SLAVES-1:0]            HREADYOUT_S,
  input  logic [NUM_SLAVES-1:0]            HRESP_S,
  output logic [DATA_WIDTH-1:0]            HRDATA,
  output logic                             HREADY,
  output logic                             HRESP,
  output logic [15:0]                      ERR_COUNT
);

  localparam int IDX_W = (NUM_SLAVES > 1) ? $clog2(NUM_SLAVES) : 1;

  typedef enum logic [1:0] {
    DS_IDLE = 2'd0,
    DS_ERR1 = 2'd1,
    DS_ERR2 = 2'd2
  } ds_state_t;

  logic [ADDR_WIDTH-1:0] region;
  logic                  mapped;
  logic [IDX_W-1:0]      addr_idx;
  logic                  err_start;

  logic                  owner_def;
  logic [IDX_W-1:0]      owner_idx;
  ds_state_t             ds_state;
  logic                  ds_ready;
  logic                  ds_resp;
  logic [15:0]           err_count;

  assign region   = HADDR >> REGION_BITS;
  assign mapped   = (region < ADDR_WIDTH'(NUM_SLAVES));
  assign addr_idx = region[IDX_W-1:0];

  // Select ignores HTRANS; slaves qualify it with HTRANS themselves.
  always_comb begin
    HSEL_VEC = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      HSEL_VEC[i] = mapped && (addr_idx == IDX_W'(i));
    end
  end

  always_comb begin
    HRDATA = '0;
    HREADY = ds_ready;
    HRESP  = ds_resp;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (!owner_def && (owner_idx == IDX_W'(i))) begin
        HRDATA = HRDATA_S[i*DATA_WIDTH +: DATA_WIDTH];
        HREADY = HREADYOUT_S[i];
        HRESP  = HRESP_S[i];
      end
    end
  end

  // An unmapped NONSEQ/SEQ is only taken when the bus is ready, i.e. the address phase completes.
  assign err_start = HREADY && !mapped && HTRANS[1];

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      owner_def <= 1'b1;
      owner_idx <= '0;
    end else if (HREADY) begin
      owner_def <= !mapped;
      owner_idx <= mapped ? addr_idx : '0;
    end
  end

  always_ff @(posedge HCLK or posedge HRESET) begin
    if (HRESET) begin
      ds_state  <= DS_IDLE;
      ds_ready  <= 1'b1;
      ds_resp   <= 1'b0;
      err_count <= '0;
    end else begin
      case (ds_state)
        DS_IDLE: begin
          if (err_start) begin
            ds_state <= DS_ERR1;
            ds_ready <= 1'b0;
            ds_resp  <= 1'b1;
          end
        end
        DS_ERR1: begin
          ds_state <= DS_ERR2;
          ds_ready <= 1'b1;
          ds_resp  <= 1'b1;
        end
        DS_ERR2: begin
          if (err_start) begin
            ds_state <= DS_ERR1;
            ds_ready <= 1'b0;
            ds_resp  <= 1'b1;
          end else begin
            ds_state <= DS_IDLE;
            ds_ready <= 1'b1;
            ds_resp  <= 1'b0;
          end
        end
        default: begin
          ds_state <= DS_IDLE;
          ds_ready <= 1'b1;
          ds_resp  <= 1'b0;
        end
      endcase
      // err_start can only fire from IDLE or ERR2, so it marks every entry to ERR1.
      if (err_start && (err_count != 16'hFFFF)) begin
        err_count <= err_count + 16'd1;
      end
    end
  end

  assign ERR_COUNT = err_count;

endmodule
